// File: rtl/lc3_useq_pkg.sv
// Shared constants for the LC-3 microsequencer: COND encodings, mask bit
// positions and the default fetch/reset address.
package lc3_useq_pkg;

  localparam logic [2:0] COND_NONE = 3'd0;
  localparam logic [2:0] COND_R    = 3'd1;
  localparam logic [2:0] COND_BEN  = 3'd2;
  localparam logic [2:0] COND_IR11 = 3'd3;
  localparam logic [2:0] COND_PSR  = 3'd4;
  localparam logic [2:0] COND_INT  = 3'd5;

  localparam int unsigned MASK_BIT_IR11 = 0;
  localparam int unsigned MASK_BIT_R    = 1;
  localparam int unsigned MASK_BIT_BEN  = 2;
  localparam int unsigned MASK_BIT_PSR  = 3;
  localparam int unsigned MASK_BIT_INT  = 4;

  localparam int unsigned USEQ_RESET_ADDR = 18;

endpackage

// File: rtl/lc3_useq_stk_lifo.sv
// useq_lifo: small push/pop stack holding micro-return addresses.
// Only the pointer is reset; entry contents persist across reset.
module useq_lifo #(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;

  assign full  = (ptr == PW'(DEPTH));
  assign empty = (ptr == '0);
  assign dout  = mem[AW'(ptr - 1'b1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/lc3_useq_stk.sv
// Registered LC-3 microsequencer with stall, sticky interrupt latch and an
// optional micro-call stack enabled by defining USEQ_CALL_STACK_EN.
module lc3_useq_stk
  import lc3_useq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RESET_ADDR = USEQ_RESET_ADDR,
  parameter int unsigned STK_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [ADDR_W-1:0] j,
  input  logic [2:0]        cond,
  input  logic              ird,
  input  logic              call,
  input  logic              ret,
  input  logic [4:0]        ir,
  input  logic              r,
  input  logic              ben,
  input  logic              psr,
  input  logic              int_req,
  input  logic              int_ack,
  output logic [ADDR_W-1:0] state,
  output logic              int_pend,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] mask, cand, disp, nxt;

  always_comb begin
    mask = '0;
    case (cond)
      COND_R:    mask[MASK_BIT_R]    = r;
      COND_BEN:  mask[MASK_BIT_BEN]  = ben;
      COND_IR11: mask[MASK_BIT_IR11] = ir[0];
      COND_PSR:  mask[MASK_BIT_PSR]  = psr;
      COND_INT:  mask[MASK_BIT_INT]  = int_pend;
      default:   mask = '0;
    endcase
  end

  assign cand = j | mask;
  // ir carries IR[15:11]; dispatch uses IR[15:12]
  assign disp = {{(ADDR_W-4){1'b0}}, ir[4:1]};

`ifdef USEQ_CALL_STACK_EN
  logic              do_call, do_ret, push, pop, full, empty;
  logic [ADDR_W-1:0] top, ret_addr;

  assign do_ret   = ~stall & ret;
  assign do_call  = ~stall & ~ret & ~ird & call;
  assign push     = do_call & ~full;
  assign pop      = do_ret & ~empty;
  assign ret_addr = state + ADDR_W'(1);

  useq_lifo #(
    .W     (ADDR_W),
    .DEPTH (STK_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      if (do_call && full) stk_ovf <= 1'b1;
      if (do_ret && empty) stk_unf <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    if (!stall) begin
      if (ret)      nxt = empty ? RST_A : top;
      else if (ird) nxt = disp;
      else          nxt = cand;
    end
  end
`else
  localparam int unsigned unused_stk_depth = STK_DEPTH;
  logic unused_ctl;
  assign unused_ctl = call ^ ret;

  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;

  always_comb begin
    nxt = state;
    if (!stall) begin
      if (ird) nxt = disp;
      else     nxt = cand;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_A;
    end else begin
      state <= nxt;
    end
  end

  // int_pend deliberately ignores stall; set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_pend <= 1'b0;
    end else if (int_req) begin
      int_pend <= 1'b1;
    end else if (int_ack) begin
      int_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_useq_stk.sv
// Self-checking bench for lc3_useq_stk: directed scenarios plus random
// stimulus against a queue-based reference model (honours USEQ_CALL_STACK_EN).
module tb_lc3_useq_stk;

  localparam int unsigned AW = 6;
  localparam int unsigned RA = 18;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst, stall, ird, call, ret, r, ben, psr, int_req, int_ack;
  logic [AW-1:0] j;
  logic [2:0]    cond;
  logic [4:0]    ir;
  logic [AW-1:0] state;
  logic          int_pend, stk_ovf, stk_unf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned m_state;
  bit          m_pend, m_ovf, m_unf;
  int unsigned m_stk[$];

  always #5 clk = ~clk;

  lc3_useq_stk #(
    .ADDR_W     (AW),
    .RESET_ADDR (RA),
    .STK_DEPTH  (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .j        (j),
    .cond     (cond),
    .ird      (ird),
    .call     (call),
    .ret      (ret),
    .ir       (ir),
    .r        (r),
    .ben      (ben),
    .psr      (psr),
    .int_req  (int_req),
    .int_ack  (int_ack),
    .state    (state),
    .int_pend (int_pend),
    .stk_ovf  (stk_ovf),
    .stk_unf  (stk_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},    32'(state),    m_state);
    check({tag, ".int_pend"}, 32'(int_pend), 32'(m_pend));
    check({tag, ".stk_ovf"},  32'(stk_ovf),  32'(m_ovf));
    check({tag, ".stk_unf"},  32'(stk_unf),  32'(m_unf));
  endtask

  task automatic model_reset();
    m_state = RA;
    m_pend  = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stk.delete();
  endtask

  // Next-state rules applied to the inputs present before the edge.
  task automatic model_edge();
    int unsigned mask = 0;
    int unsigned cand;
    bit          pend_n;
    pend_n = int_req ? 1'b1 : (int_ack ? 1'b0 : m_pend);
    if (!stall) begin
      case (cond)
        3'd1: if (r)     mask = 2;
        3'd2: if (ben)   mask = 4;
        3'd3: if (ir[0]) mask = 1;
        3'd4: if (psr)   mask = 8;
        3'd5: if (m_pend) mask = 16;
        default: mask = 0;
      endcase
      cand = int'(j) | mask;
`ifdef USEQ_CALL_STACK_EN
      if (ret) begin
        if (m_stk.size() == 0) begin
          m_state = RA;
          m_unf   = 1;
        end else begin
          m_state = m_stk.pop_back();
        end
      end else if (ird) begin
        m_state = int'(ir) / 2;
      end else begin
        if (call) begin
          if (m_stk.size() == SD) m_ovf = 1;
          else m_stk.push_back((m_state + 1) % (1 << AW));
        end
        m_state = cand;
      end
`else
      if (ird) m_state = int'(ir) / 2;
      else     m_state = cand;
`endif
    end
    m_pend = pend_n;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall = 0; j = '0; cond = 3'd0; ird = 0; call = 0; ret = 0;
    ir = '0; r = 0; ben = 0; psr = 0; int_req = 0; int_ack = 0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1;
    #1;
    model_reset();
    check_all(tag);
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    #2;
    check_all("reset");
    check("reset.const", 32'(state), 32'd18);
    @(negedge clk);
    rst = 0;

    // reset mid-operation, with int_pend set beforehand
    j = 6'd35; int_req = 1;
    step("to35");
    check("to35.const", 32'(state), 32'd35);
    idle();
    async_reset("async_rst");
    check("async_rst.const", 32'(state), 32'd18);

    // cond branches
    j = 6'h10; cond = 3'd1; r = 1; step("cond_r1");
    check("cond_r1.const", 32'(state), 32'h12);
    r = 0; step("cond_r0");
    j = 6'h14; cond = 3'd3; ir = 5'b00001; step("cond_ir11");
    check("cond_ir11.const", 32'(state), 32'h15);

    // dispatch, with and without stall
    idle(); j = 6'd5; step("pre_ird");
    ird = 1; ir = 5'b11000; cond = 3'd2; ben = 1; stall = 1;
    step("ird_stall");
    stall = 0; step("ird");
    check("ird.const", 32'(state), 32'd12);

    // interrupt latch
    idle(); int_req = 1; step("int_pulse");
    int_req = 0; cond = 3'd5; j = 6'h18; step("int_cond18");
    j = 6'h08; step("int_cond08");
    check("int_cond08.const", 32'(state), 32'h18);
    int_req = 1; int_ack = 1; step("int_both");
    int_req = 0; step("int_ack");
    check("int_ack.const", 32'(int_pend), 32'd0);

    // call/return (or plain branching when the stack is compiled out)
    idle(); j = 6'd20; step("to20");
    call = 1; j = 6'd40; step("call40");
    check("call40.const", 32'(state), 32'd40);
    call = 0; ret = 1; j = 6'd7; step("ret1");
    ret = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      call = 1; j = 6'(8 + 5 * i); step("nest_call");
    end
    call = 0; ret = 1;
    for (int unsigned i = 0; i < 5; i++) begin
      j = 6'(i); step("nest_ret");
    end
    idle();

    // random stimulus against the model
    for (int unsigned i = 0; i < 400; i++) begin
      stall   = ($urandom_range(0, 7) == 0);
      j       = 6'($urandom);
      cond    = 3'($urandom);
      ird     = ($urandom_range(0, 7) == 0);
      call    = ($urandom_range(0, 3) == 0);
      ret     = ($urandom_range(0, 4) == 0);
      ir      = 5'($urandom);
      r       = 1'($urandom);
      ben     = 1'($urandom);
      psr     = 1'($urandom);
      int_req = ($urandom_range(0, 5) == 0);
      int_ack = ($urandom_range(0, 3) == 0);
      step("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
